// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer state encoding and opcode helper functions
// for the ALU op sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } seq_state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_NOT);
  endfunction

  // Number of ALU cycles needed after the load pulse before the result is valid.
  function automatic logic [7:0] op_latency(input logic [3:0] op,
                                            input int lat_simple,
                                            input int lat_mul,
                                            input int lat_div);
    logic [7:0] lat;
    if (op == OP_MUL) begin
      lat = 8'(lat_mul);
    end else if (op == OP_DIV) begin
      lat = 8'(lat_div);
    end else begin
      lat = 8'(lat_simple);
    end
    return lat;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational request decode: legality, divide-by-zero trap and the
// ALU latency for the requested opcode.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MUL    = 17,
  parameter int LAT_DIV    = 17
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] b,
  output logic             legal,
  output logic             div_by_zero,
  output logic [7:0]       lat
);

  always_comb begin
    legal       = op_legal(op);
    div_by_zero = (op == OP_DIV) && (b == '0);
    lat         = op_latency(op, LAT_SIMPLE, LAT_MUL, LAT_DIV);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front-end for the shared multi-cycle ALU: accepts one op,
// launches the ALU, waits its fixed latency and holds the result for the consumer.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MUL    = 17,
  parameter int LAT_DIV    = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_load,
  input  logic [WIDTH-1:0] alu_res_lo,
  input  logic [WIDTH-1:0] alu_res_hi,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_err,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid is never withdrawn by this block until that edge.
  seq_state_t state;
  logic [7:0] cnt;
  logic [7:0] lat_q;

  logic       dec_legal;
  logic       dec_dbz;
  logic [7:0] dec_lat;

  alu_op_decode #(
    .WIDTH      (WIDTH),
    .LAT_SIMPLE (LAT_SIMPLE),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV)
  ) u_decode (
    .op          (req_op),
    .b           (req_b),
    .legal       (dec_legal),
    .div_by_zero (dec_dbz),
    .lat         (dec_lat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      alu_load   <= 1'b0;
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      cnt        <= '0;
      lat_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_select <= req_op;
            lat_q      <= dec_lat;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            // Traps answer straight away and never pulse the ALU.
            if (!dec_legal) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_lo    <= '0;
              rsp_hi    <= '0;
            end else if (dec_dbz) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_lo    <= '1;
              rsp_hi    <= req_a;
            end else begin
              state    <= ST_LAUNCH;
              alu_load <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          alu_load <= 1'b0;
          cnt      <= lat_q - 8'd1;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 8'd0) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_CAPTURE: begin
          rsp_lo    <= alu_res_lo;
          rsp_hi    <= alu_res_hi;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
